// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle for sync_fifo_param.
// master: producer/consumer side; slave: the FIFO itself.
interface sync_fifo_param_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  clr_err;

    modport master (
        output flush, wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and synchronous flush.
// Define SYNC_FIFO_FWFT_EN to build it as first-word-fall-through; otherwise reads
// are registered with one cycle of latency.
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AF_LEVEL   = DEPTH - 2,
    parameter int unsigned AE_LEVEL   = 2
) (
    input logic              clk,
    input logic              reset_n,
    sync_fifo_param_if.slave bus
);
    localparam int unsigned     PtrW    = ADDR_WIDTH + 1;
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [PtrW-1:0] AfLevel = PtrW'(AF_LEVEL);
    localparam logic [PtrW-1:0] AeLevel = PtrW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]       count;
    logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;
    logic                  full, empty;
    logic                  wr_accept, rd_accept;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    // Wrap bit in the pointer MSB distinguishes full from empty when indices match
    assign wr_idx = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_idx = rd_ptr_q[ADDR_WIDTH-1:0];
    assign full   = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) && (wr_idx == rd_idx);
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign count  = wr_ptr_q - rd_ptr_q;

    // Accept decisions, pointer and sticky error next-state; flush masks all traffic
    always_comb begin
        rd_accept   = bus.rd_en && !empty && !bus.flush;
        // A write into a full FIFO still fits if a read frees a slot on the same edge
        wr_accept   = bus.wr_en && (!full || rd_accept) && !bus.flush;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_accept) wr_ptr_d = wr_ptr_q + PtrOne;
            if (rd_accept) rd_ptr_d = rd_ptr_q + PtrOne;
        end
        // Set wins over clear when both happen on the same edge
        overflow_d  = (overflow_q && !bus.clr_err) || (bus.wr_en && !wr_accept && !bus.flush);
        underflow_d = (underflow_q && !bus.clr_err) || (bus.rd_en && empty && !bus.flush);
    end

    // Pointer and error flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents need no reset since empty pointers hide them
    always_ff @(posedge clk) begin
        if (wr_accept) mem_q[wr_idx] <= bus.wr_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented straight from storage while anything is queued
    assign bus.rd_data  = empty ? '0 : mem_q[rd_idx];
    assign bus.rd_valid = !empty;
`else
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Registered read port: one-cycle valid pulse per accepted read, data holds otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (bus.flush) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            if (rd_accept) rd_data_q <= mem_q[rd_idx];
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.count        = count;
    assign bus.almost_full  = (count >= AfLevel);
    assign bus.almost_empty = (count <= AeLevel);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO: next-generation data buffer for UART, packet and streaming paths. Configurable data width and power-of-two depth, with occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. Optionally compiled as first-word-fall-through (FWFT). Single clock domain, sits between producer and consumer logic.

## Interface

**Parameters**

- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 16, number of entries; must be a power of two, at least 4.
- ADDR_WIDTH, 4, log2(DEPTH); pointer index width.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

**Ports** (one clock; reset is asynchronous and active-low)

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of contents and pointers.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- rd_en  in  1  read request / pop.
- rd_data  out  DATA_WIDTH  read word.
- rd_valid  out  1  rd_data holds a valid word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full and not accepted.
- underflow  out  1  sticky: read attempted while empty.
- clr_err  in  1  synchronous clear of overflow/underflow.

## Operation

- Storage: DEPTH x DATA_WIDTH array. wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the MSB is a wrap bit. Index = low ADDR_WIDTH bits; wrap from DEPTH-1 to 0 is natural.
- full = (ptr MSBs differ) && (index bits equal). empty = pointers equal. count = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
- Write accepted when wr_en && (!full || read accepted same cycle). An accepted write stores at wr_ptr and increments wr_ptr.
- Read accepted when rd_en && !empty. An accepted read increments rd_ptr.
- Simultaneous read and write:
  - When full: both accepted; count unchanged.
  - When empty: write accepted, read rejected, underflow set.
- Rejected write when full sets overflow. Memory and pointers are unchanged.
- overflow and underflow hold until clr_err or reset. If clr_err and a new error occur in the same cycle, the flag is set (set wins).
- flush:
  - Pointers go to 0; rd_valid goes to 0.
  - Error flags are kept.
  - Memory contents are don't-care.
  - A write or read in the same cycle as flush is ignored.
- Priority: reset_n > flush > read/write.

## Timing

- Reset (async assert, sync deassert by the system):
  - rd_data = 0, rd_valid = 0.
  - full = 0, empty = 1, almost_full = 0, almost_empty = 1.
  - count = 0, overflow = 0, underflow = 0.
  - Pointers = 0.
- Reset asserted mid-operation: all contents are discarded and outputs take their reset values immediately (no clock needed).
- Standard mode read latency is 1 cycle. rd_data and rd_valid are registered the cycle after the accepted read. rd_valid is high for exactly one cycle per accepted read. rd_data holds its last value otherwise.
- All status outputs are registered or derived from registered pointers. They reflect the edge's accepted operations in the following cycle.
- Write-to-empty-deassert latency: 1 cycle.

## Configuration

- SYNC_FIFO_FWFT_EN defined (FWFT mode):
  - rd_data presents the head word whenever !empty, and rd_valid = !empty.
  - rd_en acts as a pop acknowledge; the next word appears the cycle after the pop.
  - A write into an empty FIFO is visible on rd_data one cycle after the write edge.
- SYNC_FIFO_FWFT_EN not defined: standard registered-read mode as described in Timing.

## Test plan

- Reset, then write 0xA5, 0x5A, 0xFF; read 3 -> rd_data 0xA5, 0x5A, 0xFF in order. rd_valid is high one cycle after each rd_en. empty=1 and count=0 at the end.
- Write 16 words (DEPTH=16) -> full=1, count=16, almost_full set at count 14. A 17th write -> overflow=1 and contents are unchanged. A later read returns word 0.
- Read while empty -> underflow=1, rd_valid stays 0. Pulse clr_err -> underflow=0.
- Fill to full, then wr_en+rd_en together for 20 cycles with an incrementing pattern -> count stays 16, no overflow, and output order is preserved across pointer wrap.
- Write 5 words, assert flush together with wr_en -> next cycle count=0, empty=1; the flush-cycle write is discarded.
- Drop reset_n mid-burst between clock edges -> all outputs reach reset values before the next edge. With SYNC_FIFO_FWFT_EN defined, a write of 0x3C to empty shows rd_data=0x3C and rd_valid=1 one cycle later without rd_en.
